// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between four requesters and the register-bank arbiter.
//   req    : per-requester request, held until ack is seen
//   we     : per-requester write enable (1 = write, 0 = read)
//   addr   : per-requester address, requester i uses [i*AW +: AW]
//   wdata  : per-requester write data, requester i uses [i*WIDTH +: WIDTH]
//   ack    : one-hot acknowledge to the granted requester
//   rdata  : registered read data, valid while ack is high after a read
//   gnt_id : index of the current or most recent winner
//   busy   : arbiter not idle
interface reg_bank_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 2
);
    localparam int unsigned NREQ = 4;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rdata;
    logic [1:0]            gnt_id;
    logic                  busy;

    // Client side (requesters / testbench)
    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, gnt_id, busy
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, gnt_id, busy
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Shares one DEPTH x WIDTH flip-flop register bank between four requesters.
// Round-robin arbitration, one read or write per grant, four-phase req/ack.
//   clk : clock, all state changes on rising edge
//   rst : asynchronous active-high reset
//   bus : reg_bank_arbiter_if slave modport (req/we/addr/wdata in,
//         ack/rdata/gnt_id/busy out, all outputs registered)
module reg_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    reg_bank_arbiter_if.slave   bus
);
    localparam int unsigned NREQ = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic [1:0]       gnt;
    logic [1:0]       gnt_next;
    logic [NREQ-1:0]  ack_q;
    logic [NREQ-1:0]  ack_next;
    logic             busy_q;
    logic             busy_next;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_next;
    logic [WIDTH-1:0] bank [DEPTH];
    logic             bank_we;

    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic [WIDTH-1:0] bank_rd;
    logic             in_range;
    logic [1:0]       winner;
    logic [1:0]       scan_idx;
    logic             found;

    // Mux out the granted requester's command fields
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt == 2'(i)) begin
                sel_we    = bus.we[i];
                sel_addr  = bus.addr[i*AW +: AW];
                sel_wdata = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Extra MSB so DEPTH == 2^AW still compares correctly
    assign in_range = ({1'b0, sel_addr} < (AW+1)'(DEPTH));

    // Bank read mux; an address with no matching register reads as zero
    always_comb begin
        bank_rd = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel_addr == AW'(i)) begin
                bank_rd = bank[i];
            end
        end
    end

    // Round-robin: first set req bit scanning ptr, ptr+1, ... (mod 4)
    always_comb begin
        winner   = ptr;
        found    = 1'b0;
        scan_idx = ptr;
        for (int i = 0; i < int'(NREQ); i++) begin
            scan_idx = ptr + 2'(i);
            if (!found && bus.req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt;
        ack_next   = ack_q;
        rdata_next = rdata_q;
        bank_we    = 1'b0;

        unique case (state)
            IDLE: begin
                ack_next = '0;
                if (found) begin
                    gnt_next   = winner;
                    ptr_next   = winner + 2'd1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_we) begin
                    bank_we = in_range;
                end else begin
                    rdata_next = bank_rd;
                end
                ack_next   = NREQ'(1) << gnt;
                state_next = DONE;
            end
            DONE: begin
                // Hold ack until the winner withdraws its request
                if (!bus.req[gnt]) begin
                    ack_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next   = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            gnt     <= gnt_next;
            ack_q   <= ack_next;
            busy_q  <= busy_next;
            rdata_q <= rdata_next;
        end
    end

    // Register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (bank_we && (sel_addr == AW'(i))) begin
                    bank[i] <= sel_wdata;
                end
            end
        end
    end

    assign bus.ack    = ack_q;
    assign bus.rdata  = rdata_q;
    assign bus.gnt_id = gnt;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed testbench for reg_bank_arbiter (DEPTH=3 so address 3 is out of range).
module tb_reg_bank_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned AW    = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_bank_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bif ();

    reg_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rq(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d);
        bif.we[i]                 = w;
        bif.addr[i*AW +: AW]      = a;
        bif.wdata[i*WIDTH +: WIDTH] = d;
    endtask

    // Bounded wait for any ack
    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((bif.ack == 4'b0000) && (n < 8));
        chk("ack_timeout", 32'(bif.ack != 4'b0000), 32'd1);
    endtask

    // Complete one transfer for requester i and release it
    task automatic xfer(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input string tag);
        set_rq(i, w, a, d);
        bif.req[i] = 1'b1;
        wait_ack();
        chk(tag, 32'(bif.ack), 32'(4'b0001 << i));
        bif.req[i] = 1'b0;
        step();
    endtask

    initial begin
        int exp_w;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bif.req   = '0;
        bif.we    = '0;
        bif.addr  = '0;
        bif.wdata = '0;

        // Reset state
        step();
        chk("rst_ack",   32'(bif.ack),    32'h0);
        chk("rst_busy",  32'(bif.busy),   32'h0);
        chk("rst_rdata", 32'(bif.rdata),  32'h0);
        chk("rst_gnt",   32'(bif.gnt_id), 32'h0);
        rst = 1'b0;
        step();

        // Single write, then read back by requester 3
        set_rq(0, 1'b1, 2'd2, 8'hA5);
        bif.req = 4'b0001;
        step();
        chk("wr_access_busy", 32'(bif.busy), 32'h1);
        chk("wr_access_ack",  32'(bif.ack),  32'h0);
        step();
        chk("wr_done_ack",  32'(bif.ack),    32'h1);
        chk("wr_done_busy", 32'(bif.busy),   32'h1);
        chk("wr_done_gnt",  32'(bif.gnt_id), 32'h0);
        bif.req = 4'b0000;
        step();
        chk("wr_release_ack",  32'(bif.ack),  32'h0);
        chk("wr_release_busy", 32'(bif.busy), 32'h0);
        set_rq(3, 1'b0, 2'd2, 8'h00);
        bif.req = 4'b1000;
        step();
        step();
        chk("rd3_ack",   32'(bif.ack),    32'h8);
        chk("rd3_rdata", 32'(bif.rdata),  32'hA5);
        chk("rd3_gnt",   32'(bif.gnt_id), 32'h3);
        bif.req = 4'b0000;
        step();

        // Round-robin fairness from reset with all four requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 2'd0, 8'h00);
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_w = k % 4;
            wait_ack();
            chk("rr_gnt", 32'(bif.gnt_id), 32'(exp_w));
            chk("rr_ack", 32'(bif.ack), 32'(4'b0001 << exp_w));
            bif.req[exp_w] = 1'b0;
            step();
            bif.req[exp_w] = 1'b1;
        end
        // Grant 1 to move ptr to 2, then 0 must beat 1
        bif.req = 4'b0010;
        wait_ack();
        chk("rr_ptr_setup", 32'(bif.gnt_id), 32'h1);
        bif.req = 4'b0000;
        step();
        bif.req = 4'b0011;
        wait_ack();
        chk("rr_wrap_first", 32'(bif.gnt_id), 32'h0);
        bif.req = 4'b0010;
        step();
        wait_ack();
        chk("rr_wrap_second", 32'(bif.gnt_id), 32'h1);
        bif.req = 4'b0000;
        step();

        // Handshake hold: requester 1 holds req 5 cycles after ack
        set_rq(1, 1'b0, 2'd0, 8'h00);
        set_rq(2, 1'b0, 2'd0, 8'h00);
        bif.req = 4'b0010;
        wait_ack();
        bif.req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_ack", 32'(bif.ack),    32'h2);
            chk("hold_gnt", 32'(bif.gnt_id), 32'h1);
        end
        bif.req = 4'b0100;
        step();
        chk("hold_idle_ack",  32'(bif.ack),  32'h0);
        chk("hold_idle_busy", 32'(bif.busy), 32'h0);
        step();
        chk("hold_next_access", 32'(bif.ack),    32'h0);
        chk("hold_next_gnt",    32'(bif.gnt_id), 32'h2);
        step();
        chk("hold_next_ack", 32'(bif.ack), 32'h4);
        bif.req = 4'b0000;
        step();

        // Early req drop: one-cycle pulse still writes, ack lasts one cycle
        set_rq(2, 1'b1, 2'd1, 8'h3C);
        bif.req = 4'b0100;
        step();
        bif.req = 4'b0000;
        chk("early_busy", 32'(bif.busy), 32'h1);
        step();
        chk("early_ack", 32'(bif.ack), 32'h4);
        step();
        chk("early_ack_drop", 32'(bif.ack),  32'h0);
        chk("early_idle",     32'(bif.busy), 32'h0);
        xfer(0, 1'b0, 2'd1, 8'h00, "early_rd_ack");
        chk("early_rd_data", 32'(bif.rdata), 32'h3C);

        // Out-of-range address 3 with DEPTH=3
        xfer(3, 1'b1, 2'd3, 8'hFF, "oor_wr_ack");
        chk("oor_wr_rdata_kept", 32'(bif.rdata), 32'h3C);
        xfer(3, 1'b0, 2'd3, 8'h00, "oor_rd_ack");
        chk("oor_rd_data", 32'(bif.rdata), 32'h0);
        xfer(1, 1'b0, 2'd1, 8'h00, "oor_chk1_ack");
        chk("oor_bank1", 32'(bif.rdata), 32'h3C);
        xfer(1, 1'b0, 2'd2, 8'h00, "oor_chk2_ack");
        chk("oor_bank2", 32'(bif.rdata), 32'h0);
        xfer(1, 1'b0, 2'd0, 8'h00, "oor_chk0_ack");
        chk("oor_bank0", 32'(bif.rdata), 32'h0);

        // Reset during ACCESS of a write aborts it
        set_rq(1, 1'b1, 2'd0, 8'h77);
        bif.req = 4'b0010;
        step();
        chk("mid_access_busy", 32'(bif.busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack",  32'(bif.ack),  32'h0);
        chk("mid_rst_busy", 32'(bif.busy), 32'h0);
        step();
        rst = 1'b0;
        bif.req = 4'b0000;
        for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 2'd0, 8'h00);
        step();
        bif.req = 4'b1111;
        wait_ack();
        chk("mid_restart_gnt", 32'(bif.gnt_id), 32'h0);
        chk("mid_rd0_data",    32'(bif.rdata),  32'h0);
        bif.req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Controller that shares one bank of DEPTH x WIDTH flip-flop registers between four requesters.
- Arbitrates with a round-robin pointer and performs one read or write per grant.
- Completes each transfer with a four-phase req/ack handshake.
- Sits between the register bank (clock-edge, asynchronously reset flip-flops) and the client blocks that configure or read it.

Parameters:
- WIDTH, 8, data width of each bank register
- DEPTH, 4, number of bank registers (2..16)
- AW, 2, address width; must satisfy 2^AW >= DEPTH

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester request; held high until the matching ack is seen
- we  input  4  per-requester write enable (1 = write, 0 = read)
- addr  input  4*AW  per-requester address; requester i uses bits [i*AW +: AW]
- wdata  input  4*WIDTH  per-requester write data; requester i uses bits [i*WIDTH +: WIDTH]
- ack  output  4  one-hot acknowledge to the granted requester
- rdata  output  WIDTH  registered read data; valid while ack is high after a read
- gnt_id  output  2  index of the current or most recent winner
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset is asynchronous and active-high.
  - Clears state to IDLE, every bank register to 0, ack=0, rdata=0, gnt_id=0, busy=0, round-robin pointer ptr=0.
  - Reset mid-transfer aborts the transfer; a write in flight is not performed.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If req != 0, select the winner: the first set req bit scanning ptr, ptr+1, ... mod 4.
  - Register the winner into gnt_id, set ptr = winner+1 mod 4, go to ACCESS.
  - If req == 0, stay in IDLE and leave gnt_id unchanged.
- ACCESS (exactly one cycle):
  - Sample we, addr and wdata of requester gnt_id.
  - Write: bank[addr] <= wdata at the end of this cycle.
  - Read: rdata <= bank[addr] at the end of this cycle.
  - Always go to DONE.
- DONE:
  - ack[gnt_id]=1 and all other ack bits 0 (registered, Moore output).
  - Stay in DONE while req[gnt_id]=1.
  - When req[gnt_id]=0 is sampled, go to IDLE; ack drops in the same edge.
- Latency: req rises before edge E0 -> ACCESS after E0 -> DONE with ack=1 after E1. A written value is readable from the bank after E1.
- Throughput: at most one transfer per 3 cycles; IDLE always lasts at least one cycle between grants.
- Requester obligations: we, addr and wdata stay stable from req rise until ack is seen. The block does not check these inputs outside ACCESS.
- req dropped early (during ACCESS): the operation still completes. DONE lasts one cycle with ack=1, then IDLE.
- Simultaneous requests: only the winner is served. Losers keep req high and are re-arbitrated in the next IDLE, so no requester waits more than 3 other grants.
- Out-of-range address (addr >= DEPTH):
  - Write is discarded.
  - Read returns rdata=0.
  - The transfer is still acked normally.
- rdata:
  - Holds its value until the next read completes.
  - Unchanged by writes, including a write to the same address.
- busy = (state != IDLE).

Test Plan:
- Reset, then single write: assert rst, release; req=4'b0001, we[0]=1, addr0=2, wdata0=8'hA5 -> ack=4'b0001 two edges after req, busy=1 through ACCESS/DONE; drop req -> ack=0 and IDLE next edge; then read addr 2 by requester 3 -> rdata=8'hA5, gnt_id=3.
- Round-robin fairness: after reset, hold req=4'b1111, each requester reading, and drop each req on its ack -> grant order 0,1,2,3,0; with ptr=2, req=4'b0011 -> requester 0 wins before 1.
- Handshake hold: requester 1 keeps req high for 5 cycles after ack -> ack[1] stays 1 for all 5 cycles, no other requester granted; grant to waiting requester 2 only after req[1] falls plus one IDLE cycle.
- Early req drop: req[2] pulses for one cycle (write 8'h3C to addr 1) -> write still performed, ack[2] high for exactly one cycle; subsequent read of addr 1 returns 8'h3C.
- Out-of-range access (DEPTH=3): write 8'hFF to addr 3 -> acked, bank unchanged; read addr 3 -> rdata=0, acked.
- Reset mid-operation: assert rst during ACCESS of a write of 8'h77 to addr 0 -> ack=0, busy=0 immediately; after release, read addr 0 returns 0 and arbitration restarts at requester 0.
